inst_sequencer: RTL and testbench

- Instruction initiator for the 8x8 weight-stationary core: generates the 64-bit inst word the core consumes, replacing the hand-written testbench instruction stream.
- Runs one tile: weight fetch -> kernel load -> activation fetch -> execute -> OFIFO drain into PSUM SRAM with optional accumulate.
- Sits directly above core; its inst output drives core.inst, and core.ofifo_valid feeds back as the only handshake.

---
 rtl/inst_seq_pkg.sv | 45 ++++
 rtl/inst_seq_if.sv | 28 ++
 rtl/seq_cnt.sv | 26 ++
 rtl/inst_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_inst_sequencer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/inst_seq_pkg.sv
// rtl/inst_seq_pkg.sv - inst word bit positions, idle word and FSM state encoding for inst_sequencer
package inst_seq_pkg;

    // Bit positions inside the 64-bit instruction word consumed by the core
    localparam int INST_LOAD        = 0;
    localparam int INST_EXECUTE     = 1;
    localparam int INST_L0_WR       = 2;
    localparam int INST_L0_RD       = 3;
    localparam int INST_IFIFO_RD    = 4;
    localparam int INST_IFIFO_WR    = 5;
    localparam int INST_OFIFO_RD    = 6;
    localparam int INST_A_XMEM_LSB  = 7;
    localparam int INST_WEN_XMEM    = 18;
    localparam int INST_CEN_XMEM    = 19;
    localparam int INST_A_PMEM_LSB  = 20;
    localparam int INST_WEN_PMEM    = 31;
    localparam int INST_CEN_PMEM    = 32;
    localparam int INST_ACC         = 33;
    localparam int INST_PASSTHROUGH = 34;
    localparam int INST_REN_PMEM    = 35;
    localparam int INST_OUT_STAT    = 36;
    localparam int INST_L1_WR       = 37;
    localparam int INST_RECALL_PSUM = 38;
    localparam int INST_PASS_PSUM   = 39;

    // Address fields in the word are fixed at 11 bits regardless of addr_bw
    localparam int INST_ADDR_W = 11;

    // Both SRAMs deselected (CEN=1) and in read mode (WEN=1), everything else off
    localparam logic [63:0] IDLE_INST = 64'h0000_0001_800C_0000;

    typedef enum logic [3:0] {
        IDLE,
        W_FETCH,
        W_LOAD,
        W_GAP,
        A_FETCH,
        EXEC,
        WAIT,
        DRAIN_R,
        DRAIN_W,
        DONE
    } state_t;

endpackage

// File: rtl/inst_seq_if.sv
// rtl/inst_seq_if.sv - tile request / core instruction bundle for inst_sequencer
// slave  : sequencer side (takes tile request and ofifo_valid, drives inst/busy/done)
// master : host/core side (drives tile request and ofifo_valid, observes inst/busy/done)
interface inst_seq_if #(
    parameter int addr_bw = 11,
    parameter int cnt_bw  = 11
);
    logic               start;
    logic [addr_bw-1:0] w_base;
    logic [addr_bw-1:0] a_base;
    logic [addr_bw-1:0] p_base;
    logic [cnt_bw-1:0]  n_act;
    logic               acc_en;
    logic               ofifo_valid;
    logic [63:0]        inst;
    logic               busy;
    logic               done;

    modport slave (
        input  start, w_base, a_base, p_base, n_act, acc_en, ofifo_valid,
        output inst, busy, done
    );

    modport master (
        output start, w_base, a_base, p_base, n_act, acc_en, ofifo_valid,
        input  inst, busy, done
    );
endinterface

// File: rtl/seq_cnt.sv
// rtl/seq_cnt.sv - loadable down-counter with terminal flag
// clk, reset (async active-low), load/load_val (load wins over dec),
// dec (count down, saturates at 0), cnt (current value), tc (cnt == 0)
module seq_cnt #(
    parameter int width = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [width-1:0] load_val,
    input  logic             dec,
    output logic [width-1:0] cnt,
    output logic             tc
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - width'(1);
        end
    end

    assign tc = (cnt == '0);
endmodule

// File: rtl/inst_sequencer.sv
// rtl/inst_sequencer.sv - one-tile instruction initiator for the 8x8 weight-stationary core
// clk, reset (async active-low), bus (inst_seq_if.slave: tile request in, inst/busy/done out,
// ofifo_valid from core). Optional INST_SEQ_PERF_CNT_EN adds cyc_cnt / stall_cnt outputs.
module inst_sequencer
    import inst_seq_pkg::*;
#(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int addr_bw = 11,
    parameter int cnt_bw  = 11
) (
    input  logic        clk,
    input  logic        reset,
    inst_seq_if.slave   bus
`ifdef INST_SEQ_PERF_CNT_EN
    ,
    output logic [31:0] cyc_cnt,
    output logic [31:0] stall_cnt
`endif
);
    state_t             state, next_state;
    logic [addr_bw-1:0] w_q, a_q, p_q;
    logic [cnt_bw-1:0]  n_q;
    logic               acc_q;
    logic               latch;

    logic               pc_load, pc_tc;
    logic [cnt_bw-1:0]  pc_val, pc;
    logic               vc_load, vc_dec, vc_tc;
    logic [cnt_bw-1:0]  vc_val, vc;

    logic [63:0]        inst_d, inst_q;
    logic               busy_q, done_q;
    logic [addr_bw-1:0] fetch_base, fetch_idx, pmem_addr;
    logic [cnt_bw-1:0]  fetch_top;
    state_t             first_phase;

    // Phase length counter: loaded with (length-1) on entry, tc marks the last cycle
    seq_cnt #(.width(cnt_bw)) u_phase (
        .clk(clk), .reset(reset), .load(pc_load), .load_val(pc_val),
        .dec(1'b1), .cnt(pc), .tc(pc_tc)
    );

    // Remaining-vector counter for the drain loop; tc marks the last vector
    seq_cnt #(.width(cnt_bw)) u_vec (
        .clk(clk), .reset(reset), .load(vc_load), .load_val(vc_val),
        .dec(vc_dec), .cnt(vc), .tc(vc_tc)
    );

    assign first_phase = acc_q ? DRAIN_R : DRAIN_W;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        latch      = 1'b0;
        pc_load    = 1'b0;
        pc_val     = '0;
        vc_load    = 1'b0;
        vc_val     = '0;
        vc_dec     = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                latch = 1'b1;
                if (bus.n_act == '0) begin
                    next_state = DONE;
                end else begin
                    next_state = W_FETCH;
                    pc_load    = 1'b1;
                    pc_val     = cnt_bw'(row);
                end
            end
            W_FETCH: if (pc_tc) begin
                next_state = W_LOAD;
                pc_load    = 1'b1;
                pc_val     = cnt_bw'(row - 1);
            end
            W_LOAD: if (pc_tc) begin
                next_state = W_GAP;
                pc_load    = 1'b1;
                pc_val     = cnt_bw'(col - 1);
            end
            W_GAP: if (pc_tc) begin
                next_state = A_FETCH;
                pc_load    = 1'b1;
                pc_val     = n_q;
            end
            A_FETCH: if (pc_tc) begin
                next_state = EXEC;
                pc_load    = 1'b1;
                pc_val     = n_q - cnt_bw'(1);
            end
            EXEC: if (pc_tc) next_state = WAIT;
            WAIT: if (bus.ofifo_valid) begin
                next_state = first_phase;
                vc_load    = 1'b1;
                vc_val     = n_q - cnt_bw'(1);
            end
            DRAIN_R: if (bus.ofifo_valid) next_state = DRAIN_W;
            // Without accumulate, DRAIN_W is the vector's first phase and must see a valid head
            DRAIN_W: if (acc_q || bus.ofifo_valid) begin
                if (vc_tc) begin
                    next_state = DONE;
                end else begin
                    vc_dec     = 1'b1;
                    next_state = first_phase;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Instruction word for the current state; registered below so it lands one edge later
    always_comb begin
        inst_d     = IDLE_INST;
        fetch_base = (state == A_FETCH) ? a_q : w_q;
        fetch_top  = (state == A_FETCH) ? n_q : cnt_bw'(row);
        fetch_idx  = addr_bw'(fetch_top) - addr_bw'(pc);
        pmem_addr  = p_q + addr_bw'(n_q) - addr_bw'(1) - addr_bw'(vc);
        case (state)
            W_FETCH, A_FETCH: begin
                if (!pc_tc) begin
                    inst_d[INST_CEN_XMEM] = 1'b0;
                    inst_d[INST_A_XMEM_LSB +: INST_ADDR_W] = INST_ADDR_W'(fetch_base + fetch_idx);
                end
                // L0 write trails the SRAM read by one cycle
                if (pc != fetch_top) inst_d[INST_L0_WR] = 1'b1;
            end
            W_LOAD: begin
                inst_d[INST_L0_RD] = 1'b1;
                inst_d[INST_LOAD]  = 1'b1;
            end
            EXEC: begin
                inst_d[INST_L0_RD]   = 1'b1;
                inst_d[INST_EXECUTE] = 1'b1;
            end
            DRAIN_R: if (bus.ofifo_valid) begin
                inst_d[INST_CEN_PMEM] = 1'b0;
                inst_d[INST_REN_PMEM] = 1'b1;
                inst_d[INST_A_PMEM_LSB +: INST_ADDR_W] = INST_ADDR_W'(pmem_addr);
            end
            DRAIN_W: if (acc_q || bus.ofifo_valid) begin
                inst_d[INST_CEN_PMEM]    = 1'b0;
                inst_d[INST_WEN_PMEM]    = 1'b0;
                inst_d[INST_REN_PMEM]    = 1'b0;
                inst_d[INST_ACC]         = acc_q;
                inst_d[INST_PASSTHROUGH] = ~acc_q;
                inst_d[INST_OFIFO_RD]    = 1'b1;
                inst_d[INST_A_PMEM_LSB +: INST_ADDR_W] = INST_ADDR_W'(pmem_addr);
            end
            default: inst_d = IDLE_INST;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_q    <= '0;
            a_q    <= '0;
            p_q    <= '0;
            n_q    <= '0;
            acc_q  <= 1'b0;
            inst_q <= IDLE_INST;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (latch) begin
                w_q   <= bus.w_base;
                a_q   <= bus.a_base;
                p_q   <= bus.p_base;
                n_q   <= bus.n_act;
                acc_q <= bus.acc_en;
            end
            inst_q <= inst_d;
            busy_q <= (state != IDLE);
            done_q <= (state == DONE);
        end
    end

    assign bus.inst = inst_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

`ifdef INST_SEQ_PERF_CNT_EN
    logic stall;
    // Cycles spent waiting on the OFIFO, in WAIT or at the start of a drain vector
    assign stall = ((state == WAIT) || (state == DRAIN_R) || ((state == DRAIN_W) && !acc_q))
                   && !bus.ofifo_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_cnt   <= '0;
            stall_cnt <= '0;
        end else if ((state == IDLE) && bus.start) begin
            cyc_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (state != IDLE) cyc_cnt   <= cyc_cnt + 32'd1;
            if (stall)         stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_inst_sequencer.sv
// tb/tb_inst_sequencer.sv - self-checking bench for inst_sequencer against a per-cycle instruction-stream model
module tb_inst_sequencer;
    localparam int ROW = 8;
    localparam int COL = 8;
    localparam logic [63:0] IDLE_W = (64'd1 << 32) | (64'd1 << 31) | (64'd1 << 19) | (64'd1 << 18);

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    inst_seq_if #(.addr_bw(11), .cnt_bw(11)) bus ();

`ifdef INST_SEQ_PERF_CNT_EN
    logic [31:0] cyc_cnt, stall_cnt;
`endif

    inst_sequencer #(.row(ROW), .col(COL), .addr_bw(11), .cnt_bw(11)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef INST_SEQ_PERF_CNT_EN
        ,
        .cyc_cnt(cyc_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Expected inst word after each edge of the tile, and the ofifo_valid to drive
    // in the cycle before it (0/1 forced, 2 = irrelevant, randomised)
    logic [63:0] exp_q[$];
    int          vld_q[$];
    int          stl[16];
    int          stall_total;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
        end
    endtask

    function automatic void push(input logic [63:0] w, input int v);
        exp_q.push_back(w);
        vld_q.push_back(v);
    endfunction

    function automatic logic [63:0] fetch_word(input logic [10:0] base, input int i, input int len);
        logic [63:0] w;
        logic [10:0] ad;
        w = IDLE_W;
        if (i < len) begin
            ad = base + 11'(i);
            w[19] = 1'b0;
            w[17:7] = ad;
        end
        if (i >= 1) w[2] = 1'b1;
        return w;
    endfunction

    function automatic void build(input logic [10:0] wb, input logic [10:0] ab, input logic [10:0] pb,
                                  input int n, input bit acc, input int wl);
        logic [63:0] w;
        logic [10:0] pa;
        exp_q.delete();
        vld_q.delete();
        stall_total = wl;
        if (n == 0) begin
            push(IDLE_W, 2);
            stall_total = 0;
            return;
        end
        for (int i = 0; i <= ROW; i++) push(fetch_word(wb, i, ROW), 2);
        for (int i = 0; i < ROW; i++)  push(IDLE_W | 64'h9, 2);
        for (int i = 0; i < COL; i++)  push(IDLE_W, 2);
        for (int i = 0; i <= n; i++)   push(fetch_word(ab, i, n), 2);
        for (int i = 0; i < n; i++)    push(IDLE_W | 64'hA, 2);
        for (int i = 0; i < wl; i++)   push(IDLE_W, 0);
        push(IDLE_W, 1);
        for (int j = 0; j < n; j++) begin
            pa = pb + 11'(j);
            stall_total += stl[j];
            for (int s = 0; s < stl[j]; s++) push(IDLE_W, 0);
            if (acc) begin
                w = IDLE_W;
                w[32] = 1'b0;
                w[35] = 1'b1;
                w[30:20] = pa;
                push(w, 1);
            end
            w = IDLE_W;
            w[32] = 1'b0;
            w[31] = 1'b0;
            w[30:20] = pa;
            w[33] = acc;
            w[34] = ~acc;
            w[6] = 1'b1;
            push(w, acc ? 2 : 1);
        end
        push(IDLE_W, 2);
    endfunction

    function automatic logic drv(input int v);
        return (v == 2) ? 1'($urandom % 2) : 1'(v);
    endfunction

    task automatic run_tile(input logic [10:0] wb, input logic [10:0] ab, input logic [10:0] pb,
                            input int n, input bit acc, input int wl, input int spur, input int abort_at);
        int len;
        build(wb, ab, pb, n, acc, wl);
        len = exp_q.size();
        @(negedge clk);
        bus.w_base = wb; bus.a_base = ab; bus.p_base = pb;
        bus.n_act = 11'(n); bus.acc_en = acc; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.ofifo_valid = drv(vld_q[0]);
        for (int k = 0; k < len; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("inst[%0d]", k), bus.inst, exp_q[k]);
            chk($sformatf("busy[%0d]", k), {63'd0, bus.busy}, 64'd1);
            chk($sformatf("done[%0d]", k), {63'd0, bus.done}, (k == len - 1) ? 64'd1 : 64'd0);
            if (k == abort_at) begin
                #2 reset = 1'b0;
                #1;
                chk("abort_inst", bus.inst, IDLE_W);
                chk("abort_busy", {63'd0, bus.busy}, 64'd0);
                chk("abort_done", {63'd0, bus.done}, 64'd0);
`ifdef INST_SEQ_PERF_CNT_EN
                chk("abort_cyc", {32'd0, cyc_cnt}, 64'd0);
`endif
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            // Request inputs change mid-tile; the latched copy must be used
            if (k == 2) begin
                bus.w_base = 11'($urandom); bus.a_base = 11'($urandom);
                bus.p_base = 11'($urandom); bus.n_act = 11'($urandom_range(0, 9));
                bus.acc_en = 1'($urandom % 2);
            end
            if (k + 1 < len) bus.ofifo_valid = drv(vld_q[k + 1]);
            bus.start = (k + 1 == spur);
        end
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        chk("post_inst", bus.inst, IDLE_W);
        chk("post_busy", {63'd0, bus.busy}, 64'd0);
        chk("post_done", {63'd0, bus.done}, 64'd0);
`ifdef INST_SEQ_PERF_CNT_EN
        chk("cyc_cnt", {32'd0, cyc_cnt}, 64'(len));
        chk("stall_cnt", {32'd0, stall_cnt}, 64'(stall_total));
`endif
    endtask

    initial begin
        int n;
        bus.start = 1'b0; bus.w_base = '0; bus.a_base = '0; bus.p_base = '0;
        bus.n_act = '0; bus.acc_en = 1'b0; bus.ofifo_valid = 1'b0;
        foreach (stl[i]) stl[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_inst", bus.inst, IDLE_W);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
`ifdef INST_SEQ_PERF_CNT_EN
        chk("rst_cyc", {32'd0, cyc_cnt}, 64'd0);
        chk("rst_stall", {32'd0, stall_cnt}, 64'd0);
`endif
        @(negedge clk);
        reset = 1'b1;

        // Stall-free tile, overwrite mode, with a start pulse while busy
        run_tile(11'd0, 11'd16, 11'd0, 4, 1'b0, 0, 10, -1);
        // Same tile, accumulate mode
        run_tile(11'd0, 11'd16, 11'd0, 4, 1'b1, 0, -1, -1);
        // 5 WAIT stall cycles and 2 stall cycles before vector 2
        stl[2] = 2;
        run_tile(11'd0, 11'd16, 11'd0, 4, 1'b0, 5, -1, -1);
        stl[2] = 0;
        // PSUM address wrap
        run_tile(11'd5, 11'd2045, 11'd2046, 3, 1'b1, 0, -1, -1);
        run_tile(11'd5, 11'd2045, 11'd2046, 3, 1'b0, 1, -1, -1);
        // Empty tile
        run_tile(11'd100, 11'd200, 11'd300, 0, 1'b0, 0, -1, -1);
        // Reset mid-EXEC, then a normal tile
        run_tile(11'd0, 11'd16, 11'd0, 4, 1'b0, 0, -1, 31);
        run_tile(11'd7, 11'd9, 11'd11, 2, 1'b1, 0, -1, -1);

        for (int t = 0; t < 12; t++) begin
            n = $urandom_range(1, 6);
            foreach (stl[i]) stl[i] = ($urandom % 2 == 0) ? 0 : $urandom_range(1, 2);
            run_tile(11'($urandom), 11'($urandom), 11'($urandom), n, 1'($urandom % 2),
                     $urandom_range(0, 3), $urandom_range(0, 20), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
